// File: rtl/text_buffer_writer.sv
// Writable character buffer for the text renderer. Characters arrive over a
// valid/ready handshake and are placed at a wrapping cursor. The renderer reads
// cells via char_xy -> char_code. A clear sweep blanks the RAM one cell per cycle.
module text_buffer_writer #(
    parameter int unsigned TEXT_SIZE_X = 16,
    parameter int unsigned TEXT_SIZE_Y = 4,
    parameter logic [6:0]  BLANK_CHAR  = 7'h20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [6:0] wr_char,
    input  logic       clear_req,
    output logic       busy,
    output logic [7:0] cursor_xy,
    input  logic [7:0] char_xy,
    output logic [6:0] char_code
);

    localparam int unsigned CELLS = TEXT_SIZE_X * TEXT_SIZE_Y;
    localparam int unsigned IDX_W = (CELLS > 1) ? $clog2(CELLS) : 1;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    localparam logic [6:0]       CHAR_LF   = 7'h0A;
    localparam logic [6:0]       CHAR_CR   = 7'h0D;
    localparam logic [3:0]       LAST_X    = 4'(TEXT_SIZE_X - 1);
    localparam logic [3:0]       LAST_Y    = 4'(TEXT_SIZE_Y - 1);
    localparam logic [IDX_W-1:0] LAST_CELL = IDX_W'(CELLS - 1);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e           state_q;
    logic [IDX_W-1:0] sweep_q;
    logic [3:0]       cursor_x_q;
    logic [3:0]       cursor_y_q;

    // Cell RAM, linear index y*TEXT_SIZE_X + x
    logic [6:0] mem [DEPTH];

    logic             transfer;
    logic             is_lf;
    logic             is_cr;
    logic [3:0]       next_y;
    logic [IDX_W-1:0] cursor_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_in_range;
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [6:0]       mem_wdata;

    // Handshake, cursor arithmetic and RAM write/read port decode
    always_comb begin
        // Ready only in a clean idle cycle; a pending clear wins over a write
        wr_ready    = rst && (state_q == StIdle) && !clear_req;
        transfer    = wr_valid && wr_ready;
        is_lf       = (wr_char == CHAR_LF);
        is_cr       = (wr_char == CHAR_CR);
        next_y      = (cursor_y_q == LAST_Y) ? 4'd0 : cursor_y_q + 4'd1;
        cursor_idx  = IDX_W'(int'(cursor_y_q) * TEXT_SIZE_X + int'(cursor_x_q));
        rd_idx      = IDX_W'(int'(char_xy[3:0]) * TEXT_SIZE_X + int'(char_xy[7:4]));
        rd_in_range = (32'(char_xy[7:4]) < TEXT_SIZE_X) && (32'(char_xy[3:0]) < TEXT_SIZE_Y);
        char_code   = rd_in_range ? mem[rd_idx] : 7'h00;

        mem_we    = 1'b0;
        mem_waddr = cursor_idx;
        mem_wdata = wr_char;
        if (rst) begin
            if (state_q == StClear) begin
                mem_we    = 1'b1;
                mem_waddr = sweep_q;
                mem_wdata = BLANK_CHAR;
            end else if (transfer && !is_lf && !is_cr) begin
                mem_we = 1'b1;
            end
        end
    end

    // RAM write port; contents are never reset, the clear sweep blanks them
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Control FSM: clear sweep and cursor movement
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= StClear;
            sweep_q    <= '0;
            cursor_x_q <= 4'd0;
            cursor_y_q <= 4'd0;
        end else begin
            case (state_q)
                StClear: begin
                    if (sweep_q == LAST_CELL) begin
                        state_q <= StIdle;
                        sweep_q <= '0;
                    end else begin
                        sweep_q <= sweep_q + IDX_W'(1);
                    end
                end
                StIdle: begin
                    if (clear_req) begin
                        state_q    <= StClear;
                        sweep_q    <= '0;
                        cursor_x_q <= 4'd0;
                        cursor_y_q <= 4'd0;
                    end else if (transfer) begin
                        if (is_lf) begin
                            cursor_x_q <= 4'd0;
                            cursor_y_q <= next_y;
                        end else if (!is_cr) begin
                            if (cursor_x_q == LAST_X) begin
                                cursor_x_q <= 4'd0;
                                cursor_y_q <= next_y;
                            end else begin
                                cursor_x_q <= cursor_x_q + 4'd1;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Status outputs straight from registered state
    always_comb begin
        busy      = (state_q == StClear);
        cursor_xy = {cursor_x_q, cursor_y_q};
    end

endmodule

// File: tb/tb_text_buffer_writer.sv
// Scoreboard bench for text_buffer_writer (16x4 defaults). A reference model
// keeps the screen as a 2-D array plus an (x,y) cursor; accepted characters push
// their expected cursor into a queue that a negedge monitor pops and checks.
module tb_text_buffer_writer;

    localparam int X = 16;
    localparam int Y = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_valid = 1'b0;
    logic [6:0] wr_char = 7'h00;
    logic       clear_req = 1'b0;
    logic [7:0] char_xy = 8'h00;
    logic       wr_ready;
    logic       busy;
    logic [7:0] cursor_xy;
    logic [6:0] char_code;

    int checks = 0;
    int errors = 0;

    logic [6:0] model_mem [16][16];
    int         cur_x = 0;
    int         cur_y = 0;
    logic [7:0] exp_q [$];
    bit         pend = 1'b0;

    text_buffer_writer #(
        .TEXT_SIZE_X(X),
        .TEXT_SIZE_Y(Y),
        .BLANK_CHAR (7'h20)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_char  (wr_char),
        .clear_req(clear_req),
        .busy     (busy),
        .cursor_xy(cursor_xy),
        .char_xy  (char_xy),
        .char_code(char_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: blank screen, cursor home
    task automatic model_clear();
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                model_mem[x][y] = (x < X && y < Y) ? 7'h20 : 7'h00;
            end
        end
        cur_x = 0;
        cur_y = 0;
    endtask

    // Model: effect of one accepted character
    task automatic model_apply(input logic [6:0] c);
        if (c == 7'h0A) begin
            cur_x = 0;
            cur_y = (cur_y + 1) % Y;
        end else if (c != 7'h0D) begin
            model_mem[cur_x][cur_y] = c;
            cur_x = cur_x + 1;
            if (cur_x == X) begin
                cur_x = 0;
                cur_y = (cur_y + 1) % Y;
            end
        end
    endtask

    function automatic logic [7:0] model_cursor();
        return {cur_x[3:0], cur_y[3:0]};
    endfunction

    function automatic logic [6:0] rand_printable();
        return 7'($urandom_range(33, 126));
    endfunction

    // Offer one character; in idle with no clear it must be taken this cycle
    task automatic send(input logic [6:0] c);
        wr_valid = 1'b1;
        wr_char  = c;
        #1;
        check("wr_ready_idle", wr_ready, 1);
        model_apply(c);
        exp_q.push_back(model_cursor());
        @(posedge clk);
        #1;
    endtask

    // Compare every addressable cell (in and out of range) against the model
    task automatic check_all(input string tag);
        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                char_xy = {x[3:0], y[3:0]};
                #1;
                check($sformatf("%s_cell_%02h", tag, char_xy), char_code, model_mem[x][y]);
            end
        end
        @(posedge clk);
        #1;
    endtask

    // Count cycles with busy high; optionally pulse clear_req at cycle pulse_at
    task automatic count_busy(output int n, input int pulse_at);
        int ready_bad;
        n = 0;
        ready_bad = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (wr_ready !== 1'b0) ready_bad++;
            if (n == pulse_at) clear_req = 1'b1;
            @(posedge clk);
            #1;
            clear_req = 1'b0;
        end
        check("ready_low_during_sweep", ready_bad, 0);
    endtask

    // Monitor: a transfer seen at one negedge is scored at the next
    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                check("unexpected_transfer", 1, 0);
            end else begin
                check("cursor_after_transfer", cursor_xy, exp_q.pop_front());
            end
        end
        pend = rst && wr_valid && wr_ready;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int    n;
        string s;
        time   t0;

        // 1. Reset and initial sweep
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        count_busy(n, 0);
        check("reset_sweep_len", n, 64);
        check("busy_after_sweep", busy, 0);
        check("ready_after_sweep", wr_ready, 1);
        check("cursor_after_reset", cursor_xy, 8'h00);
        check_all("reset");

        // 2. "Sky Hop" back-to-back, plus write/read timing on cell 0
        s = "Sky Hop";
        char_xy = 8'h00;
        wr_valid = 1'b1;
        wr_char = 7'h53;
        #1;
        check("read_old_during_write", char_code, 7'h20);
        t0 = $time;
        for (int i = 0; i < s.len(); i++) begin
            if (i == 1) check("read_new_next_cycle", char_code, 7'h53);
            send(7'(s[i]));
        end
        wr_valid = 1'b0;
        check("sky_hop_cycles", 32'((($time - t0) + 1) / 10), 7);
        check("cursor_sky_hop", cursor_xy, 8'h70);
        check_all("skyhop");

        // 3. Line wrap and last-cell wrap
        model_clear();
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        count_busy(n, 0);
        for (int i = 0; i < 17; i++) send(7'(8'h41 + i));
        wr_valid = 1'b0;
        check("cursor_after_q", cursor_xy, 8'h11);
        check_all("wrap_line");
        while (!(cur_x == 15 && cur_y == 3)) send(rand_printable());
        wr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("cursor_at_last", cursor_xy, 8'hF3);
        send(7'h5A);
        wr_valid = 1'b0;
        check("cursor_wrap_home", cursor_xy, 8'h00);
        check_all("wrap_last");

        // 4. Newline and carriage return from cursor 8'h52
        while (!(cur_x == 5 && cur_y == 2)) send(rand_printable());
        send(7'h0A);
        check("cursor_after_lf", cursor_xy, 8'h03);
        send(7'h0D);
        check("cursor_after_cr", cursor_xy, 8'h03);
        send(7'h58);
        wr_valid = 1'b0;
        check_all("lf_cr");

        // Random traffic with control codes and idle gaps
        for (int i = 0; i < 60; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            send(r == 0 ? 7'h0A : (r == 1 ? 7'h0D : rand_printable()));
            if ($urandom_range(0, 3) == 0) begin
                wr_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        wr_valid = 1'b0;
        check_all("random");

        // 5. Clear collides with a write; second clear mid-sweep is ignored
        clear_req = 1'b1;
        wr_valid = 1'b1;
        wr_char = 7'h57;
        #1;
        check("ready_low_on_clear", wr_ready, 0);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        wr_valid = 1'b0;
        model_clear();
        count_busy(n, 10);
        check("clear_sweep_len", n, 64);
        check("cursor_after_clear", cursor_xy, 8'h00);
        check_all("clear");

        // 6. Out-of-range reads and reset mid-sweep
        char_xy = 8'h05;
        #1;
        check("read_y_out_of_range", char_code, 7'h00);
        char_xy = 8'hFF;
        #1;
        check("read_ff", char_code, 7'h00);
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) send(rand_printable());
        wr_valid = 1'b0;
        clear_req = 1'b1;
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        repeat (29) @(posedge clk);
        #1;
        check("busy_before_mid_reset", busy, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_clear();
        count_busy(n, 0);
        check("mid_reset_sweep_len", n, 64);
        check("cursor_after_mid_reset", cursor_xy, 8'h00);
        check_all("mid_reset");

        @(negedge clk);
        #1;
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
